// File: rtl/lsu_dmem_resp.sv
// ---------------------------------------------------------------------------
// lsu_dmem_resp
// Data-memory responder for the LSU request interface. It accepts one request
// at a time and inserts WAIT_CYCLES wait states. It then performs a
// byte-enabled word access on an internal array and returns one response
// per granted request.
//
// Optional feature macro: DMEM_ERR_CHECK_EN
//   defined   - out-of-range addresses and illegal byte-enable patterns raise
//               data_err_o and suppress the access.
//   undefined - data_err_o is always 0, the word index wraps modulo
//               DEPTH_WORDS and every byte-enable pattern is accepted.
// ---------------------------------------------------------------------------
module lsu_dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD_C = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

`ifdef DMEM_ERR_CHECK_EN
    localparam logic [32:0] SPAN_BYTES_C = 33'(DEPTH_WORDS) << 2;

    // Offset is relative to BASE_ADDR; addresses below the base wrap to huge values.
    function automatic logic addr_in_range(input logic [31:0] off);
        return ({1'b0, off} < SPAN_BYTES_C);
    endfunction

    // Only naturally aligned byte, halfword and word patterns are legal.
    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    state_e         state_r, state_s;
    logic [3:0]     cnt_r, cnt_s;
    logic           we_r;
    logic [3:0]     be_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic           gnt_s;
    logic           access_s;
    logic           acc_we_s;
    logic [3:0]     acc_be_s;
    logic [31:0]    acc_addr_s;
    logic [31:0]    acc_wdata_s;
    logic [31:0]    acc_off_s;
    logic [AW-1:0]  idx_s;
    logic           acc_err_s;
    logic           mem_we_s;
    logic           unused_off_s;
    logic           rvalid_r;
    logic [31:0]    rdata_r;
    logic           err_r;
    logic [31:0]    mem_r [DEPTH_WORDS];

    // FSM state and wait counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // FSM next-state and wait-counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (gnt_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_LOAD_C;
                    end else begin
                        state_s = ST_RESP;
                        cnt_s   = 4'd0;
                    end
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM outputs: grant, and access strobe for the edge entering RESP
    always_comb begin
        gnt_s    = data_req_i && ((state_r == ST_IDLE) || (state_r == ST_RESP)) && rst_ni;
        access_s = (state_s == ST_RESP);
    end

    // Capture the granted request for the wait-state path
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (gnt_s) begin
            we_r    <= data_we_i;
            be_r    <= data_be_i;
            addr_r  <= data_addr_i;
            wdata_r <= data_wdata_i;
        end else begin
            we_r    <= we_r;
            be_r    <= be_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Select access fields: with no wait states the access happens on the grant edge itself
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_we_s    = data_we_i;
            acc_be_s    = data_be_i;
            acc_addr_s  = data_addr_i;
            acc_wdata_s = data_wdata_i;
        end else begin
            acc_we_s    = we_r;
            acc_be_s    = be_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        acc_off_s = acc_addr_s - BASE_ADDR;
        idx_s     = acc_off_s[AW+1:2];
`ifdef DMEM_ERR_CHECK_EN
        acc_err_s = !addr_in_range(acc_off_s) || !be_legal(acc_be_s);
`else
        acc_err_s = 1'b0;
`endif
        mem_we_s  = access_s && acc_we_s && !acc_err_s && rst_ni;
    end

    assign unused_off_s = ^{acc_off_s[31:AW+2], acc_off_s[1:0]};

    // Byte-enabled store into the array; contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers: pulse rvalid and hold rdata/err between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end else if (access_s) begin
            rvalid_r <= 1'b1;
            err_r    <= acc_err_s;
            if (acc_we_s || acc_err_s) begin
                rdata_r <= 32'd0;
            end else begin
                rdata_r <= mem_r[idx_s];
            end
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= rdata_r;
            err_r    <= err_r;
        end
    end

    assign data_gnt_o    = gnt_s;
    assign data_rvalid_o = rvalid_r;
    assign data_rdata_o  = rdata_r;
    assign data_err_o    = err_r;

endmodule

// File: tb/tb_lsu_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_resp
// Two responders share one clock: instance 0 with two wait states and
// instance 1 with none. A transaction-level model predicts grant, response
// cycle, rdata and err for each responder.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_resp;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_2000;

    typedef struct {
        int          due;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Cycle counter used to time responses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model: error rule from the address window and legal byte-enable set
    function automatic logic mdl_err(input logic [31:0] a, input logic [3:0] b);
`ifdef DMEM_ERR_CHECK_EN
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || (off >= 4 * DEPTH) ||
               !(b inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
        return (a === 32'hxxxx_xxxx) && (b === 4'hx);
`endif
    endfunction

    // Model: word index, byte offset taken modulo the array size
    function automatic int mdl_idx(input logic [31:0] a);
        longint off;
        longint span;
        span = 4 * DEPTH;
        off  = longint'(a) - longint'(BASE);
        off  = ((off % span) + span) % span;
        return int'(off / 4);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gu
        localparam int W = (g == 0) ? 2 : 0;
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
        txn_t        q[$];
        logic [31:0] mem_m [DEPTH];
        logic [31:0] last_rdata = 32'd0;
        int          pend_n = 0;

        lsu_dmem_resp #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (W),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .data_req_i    (req[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_addr_i   (addr[g]),
            .data_wdata_i  (wdata[g]),
            .data_gnt_o    (gnt),
            .data_rvalid_o (rvalid),
            .data_rdata_o  (rdata),
            .data_err_o    (err)
        );

        // Monitor: compare grant and response against the transaction model
        always @(negedge clk) begin
            txn_t        t;
            logic        exp_gnt;
            logic        exp_err;
            logic [31:0] exp_rd;
            int          idx;
            if (!rst_n) begin
                q.delete();
                pend_n = 0;
                chk("rst_gnt",    32'(gnt),    32'd0);
                chk("rst_rvalid", 32'(rvalid), 32'd0);
                chk("rst_rdata",  rdata,       32'd0);
                chk("rst_err",    32'(err),    32'd0);
            end else begin
                exp_gnt = req[g] && ((q.size() == 0) || (q[0].due == cyc));
                chk($sformatf("gnt%0d", g), 32'(gnt), 32'(exp_gnt));
                if ((q.size() > 0) && (q[0].due == cyc)) begin
                    t       = q.pop_front();
                    exp_err = mdl_err(t.addr, t.be);
                    idx     = mdl_idx(t.addr);
                    exp_rd  = (t.we || exp_err) ? 32'd0 : mem_m[idx];
                    chk($sformatf("rvalid%0d", g), 32'(rvalid), 32'd1);
                    chk($sformatf("rdata%0d", g),  rdata,       exp_rd);
                    chk($sformatf("err%0d", g),    32'(err),    32'(exp_err));
                    if (!t.we && !exp_err) last_rdata = rdata;
                    if (t.we && !exp_err) begin
                        for (int b = 0; b < 4; b++)
                            if (t.be[b]) mem_m[idx][8*b +: 8] = t.wdata[8*b +: 8];
                    end
                end else begin
                    chk($sformatf("no_rvalid%0d", g), 32'(rvalid), 32'd0);
                end
                if (gnt && req[g]) begin
                    t.due = cyc + W + 1; t.we = we[g]; t.be = be[g];
                    t.addr = addr[g]; t.wdata = wdata[g];
                    q.push_back(t);
                end
                pend_n = q.size();
            end
        end
    end

    function automatic logic gnt_of(input int i);
        return (i == 0) ? gu[0].gnt : gu[1].gnt;
    endfunction

    function automatic logic [31:0] last_of(input int i);
        return (i == 0) ? gu[0].last_rdata : gu[1].last_rdata;
    endfunction

    function automatic int pend_of(input int i);
        return (i == 0) ? gu[0].pend_n : gu[1].pend_n;
    endfunction

    task automatic wait_gnt(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_of(i) && n < 100);
        chk($sformatf("gnt_wait%0d", i), 32'(gnt_of(i)), 32'd1);
    endtask

    task automatic issue(input int i, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        wait_gnt(i);
    endtask

    task automatic idle(input int i, input int n);
        @(posedge clk); #1;
        req[i] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic settle(input int i);
        idle(i, 6);
        chk($sformatf("drain%0d", i), 32'(pend_of(i)), 32'd0);
    endtask

    task automatic rand_txn(input int i);
        int          sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        if (sel < 8)       a = BASE + 32'(4 * sel);
        else if (sel == 8) a = BASE + 32'(4 * (DEPTH - 1));
        else               a = BASE - 32'd4;
        if ($urandom_range(0, 7) == 0) a = a + 32'(4 * DEPTH);
        a = a | 32'($urandom_range(0, 3));
        issue(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(0, 2));
    endtask

    // Global time limit so the run always ends
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; we[i] = 1'b1; be[i] = 4'b1111;
            addr[i] = 32'h0000_2004; wdata[i] = 32'h1122_3344;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("gnt_after_rst0", 32'(gu[0].gnt), 32'd1);
        chk("gnt_after_rst1", 32'(gu[1].gnt), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        repeat (5) @(posedge clk);

        // Known contents for every word the random phase can reach
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) issue(i, 1'b1, 4'b1111, BASE + 32'(4 * k), $urandom);
            issue(i, 1'b1, 4'b1111, BASE + 32'(4 * (DEPTH - 1)), $urandom);
            settle(i);
        end

        // Full-word store then load
        issue(0, 1'b1, 4'b1111, 32'h0000_2000, 32'hDEAD_BEEF);
        issue(0, 1'b0, 4'b1111, 32'h0000_2000, 32'd0);
        settle(0);
        chk("deadbeef", last_of(0), 32'hDEAD_BEEF);

        // Single-byte store into lane 2
        issue(0, 1'b1, 4'b1111, 32'h0000_2004, 32'h1122_3344);
        issue(0, 1'b1, 4'b0100, 32'h0000_2006, 32'hFFA5_FFFF);
        issue(0, 1'b0, 4'b1111, 32'h0000_2004, 32'd0);
        settle(0);
        chk("byte_lane2", last_of(0), 32'h11A5_3344);

`ifdef DMEM_ERR_CHECK_EN
        issue(0, 1'b0, 4'b1111, 32'h0000_1FFC, 32'd0);
        issue(0, 1'b1, 4'b0110, 32'h0000_2000, 32'h0000_0000);
        issue(0, 1'b0, 4'b1111, 32'h0000_2000, 32'd0);
        settle(0);
        chk("err_no_write", last_of(0), 32'hDEAD_BEEF);
`else
        issue(0, 1'b1, 4'b1111, BASE + 32'(4 * DEPTH), 32'h600D_CAFE);
        issue(0, 1'b0, 4'b1111, 32'h0000_2000, 32'd0);
        settle(0);
        chk("alias_word0", last_of(0), 32'h600D_CAFE);
`endif

        // Reset while a store sits in its wait states
        issue(0, 1'b1, 4'b1111, 32'h0000_2010, 32'h5555_AAAA);
        settle(0);
        issue(0, 1'b1, 4'b1111, 32'h0000_2010, 32'hCAFE_F00D);
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        issue(0, 1'b0, 4'b1111, 32'h0000_2010, 32'd0);
        settle(0);
        chk("reset_drop", last_of(0), 32'h5555_AAAA);

        // Zero wait states: four loads streamed back to back
        for (int k = 0; k < 4; k++) issue(1, 1'b0, 4'b1111, BASE + 32'(4 * k), 32'd0);
        settle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 80; n++) rand_txn(i);
            settle(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
